// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

   localparam int unsigned D_W_MIN     = 5;
   localparam int unsigned CFG_DBITS_W = 4;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BRKWAIT
   } rx_state_e;

   typedef struct packed {
      logic [CFG_DBITS_W-1:0] dbits;
      parity_e                parity;
      logic                   stop2;
   } uart_rx_cfg_t;

   // Out-of-range data-bit requests saturate to the supported window.
   function automatic logic [CFG_DBITS_W-1:0] clamp_dbits(
      input logic [CFG_DBITS_W-1:0] req,
      input logic [CFG_DBITS_W-1:0] max_bits
   );
      if (req < CFG_DBITS_W'(D_W_MIN)) begin
         return CFG_DBITS_W'(D_W_MIN);
      end
      if (req > max_bits) begin
         return max_bits;
      end
      return req;
   endfunction

   // Encoding 2'b11 is a second spelling of "no parity".
   function automatic parity_e decode_parity(input logic [1:0] raw);
      case (raw)
         2'b01:   return PAR_EVEN;
         2'b10:   return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// RX synchroniser, oversample tick counter and 3-sample majority vote.
module uart_bit_sampler #(
   parameter int unsigned B_TICK      = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic s_tick,
   input  logic rx,
   input  logic cnt_clr,
   output logic rx_sync,
   output logic bit_val,
   output logic bit_strobe,
   output logic bit_end
);

   localparam int unsigned CNT_W = $clog2(B_TICK);
   localparam int unsigned MID   = B_TICK / 2;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [1:0]             smp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         cnt_q  <= '0;
         smp_q  <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
         cnt_q  <= cnt_d;
         if (s_tick && (cnt_q == CNT_W'(MID - 1))) smp_q[0] <= rx_sync;
         if (s_tick && (cnt_q == CNT_W'(MID)))     smp_q[1] <= rx_sync;
      end
   end

   // Counter is held at zero while the receiver is idle so each frame starts aligned.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (s_tick) begin
         cnt_d = (cnt_q == CNT_W'(B_TICK - 1)) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   assign rx_sync    = sync_q[SYNC_STAGES-1];
   assign bit_strobe = s_tick && (cnt_q == CNT_W'(MID + 1));
   assign bit_end    = s_tick && (cnt_q == CNT_W'(B_TICK - 1));
   // Third sample is the live value at MID+1, voted without an extra register.
   assign bit_val    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync) | (smp_q[1] & rx_sync);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with parity/frame/break/overrun status
// and a valid/ready holding register.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned D_W         = 9,
   parameter int unsigned B_TICK      = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           s_tick,
   input  logic           rx,
   input  logic [3:0]     cfg_dbits,
   input  logic [1:0]     cfg_parity,
   input  logic           cfg_stop2,
   input  logic           rx_ready,
   output logic           rx_valid,
   output logic [D_W-1:0] rx_dout,
   output logic           err_parity,
   output logic           err_frame,
   output logic           brk_det,
   output logic           err_overrun,
   output logic           busy
);

   localparam int unsigned IDX_W = CFG_DBITS_W;

   logic rx_sync, bit_val, bit_strobe, bit_end;

   rx_state_e        state_q, state_d;
   uart_rx_cfg_t     cfg_q, cfg_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             stop_idx_q, stop_idx_d;
   logic [D_W-1:0]   shift_q, shift_d;
   logic             par_q, par_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             brk_q, brk_d;
   logic             ferr_nxt, brk_nxt;
   logic             done_c, done_brk_c, done_ferr_c;

   logic             valid_q;
   logic [D_W-1:0]   dout_q;
   logic             err_parity_q, err_frame_q, brk_det_q, overrun_q, busy_q;
   logic             accept;

   uart_bit_sampler #(
      .B_TICK      (B_TICK),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sampler (
      .clk        (clk),
      .rst        (rst),
      .s_tick     (s_tick),
      .rx         (rx),
      .cnt_clr    (state_q == ST_IDLE),
      .rx_sync    (rx_sync),
      .bit_val    (bit_val),
      .bit_strobe (bit_strobe),
      .bit_end    (bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cfg_q      <= '{dbits: 4'd8, parity: PAR_NONE, stop2: 1'b0};
         idx_q      <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         brk_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_q      <= cfg_d;
         idx_q      <= idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         brk_q      <= brk_d;
      end
   end

   // Frame FSM; brk_q stays set only while every voted bit after the start bit is 0.
   always_comb begin
      state_d     = state_q;
      cfg_d       = cfg_q;
      idx_d       = idx_q;
      stop_idx_d  = stop_idx_q;
      shift_d     = shift_q;
      par_d       = par_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      brk_d       = brk_q;
      ferr_nxt    = ferr_q | ~bit_val;
      brk_nxt     = brk_q & ~bit_val;
      done_c      = 1'b0;
      done_brk_c  = 1'b0;
      done_ferr_c = ferr_q;

      case (state_q)
         ST_IDLE: begin
            if (!rx_sync) begin
               state_d    = ST_START;
               cfg_d      = '{dbits:  clamp_dbits(cfg_dbits, IDX_W'(D_W)),
                              parity: decode_parity(cfg_parity),
                              stop2:  cfg_stop2};
               idx_d      = '0;
               stop_idx_d = 1'b0;
               shift_d    = '0;
               par_d      = 1'b0;
               perr_d     = 1'b0;
               ferr_d     = 1'b0;
               brk_d      = 1'b1;
            end
         end
         ST_START: begin
            if (bit_strobe && bit_val) begin
               state_d = ST_IDLE;
            end else if (bit_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_strobe) begin
               for (int i = 0; i < int'(D_W); i++) begin
                  if (idx_q == IDX_W'(i)) shift_d[i] = bit_val;
               end
               par_d = par_q ^ bit_val;
               brk_d = brk_nxt;
            end
            if (bit_end) begin
               if (idx_q == cfg_q.dbits - IDX_W'(1)) begin
                  state_d    = (cfg_q.parity == PAR_NONE) ? ST_STOP : ST_PARITY;
                  stop_idx_d = 1'b0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (bit_strobe) begin
               perr_d = bit_val != ((cfg_q.parity == PAR_ODD) ? ~par_q : par_q);
               brk_d  = brk_nxt;
            end
            if (bit_end) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_strobe) begin
               if (stop_idx_q == cfg_q.stop2) begin
                  // Completing at mid-bit lets the next start edge be caught early.
                  done_c      = 1'b1;
                  done_brk_c  = brk_nxt;
                  done_ferr_c = ferr_nxt | brk_nxt;
                  state_d     = brk_nxt ? ST_BRKWAIT : ST_IDLE;
               end else begin
                  ferr_d = ferr_nxt;
                  brk_d  = brk_nxt;
               end
            end else if (bit_end) begin
               stop_idx_d = 1'b1;
            end
         end
         ST_BRKWAIT: begin
            if (rx_sync) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign accept = valid_q & rx_ready;

   // Holding register: a completion in the accept cycle refills it; otherwise a full register drops the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q      <= 1'b0;
         dout_q       <= '0;
         err_parity_q <= 1'b0;
         err_frame_q  <= 1'b0;
         brk_det_q    <= 1'b0;
         overrun_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         busy_q <= (state_d != ST_IDLE);
         if (done_c && (!valid_q || accept)) begin
            valid_q      <= 1'b1;
            dout_q       <= shift_q;
            err_parity_q <= perr_q;
            err_frame_q  <= done_ferr_c;
            brk_det_q    <= done_brk_c;
            overrun_q    <= 1'b0;
         end else if (done_c) begin
            overrun_q <= 1'b1;
         end else if (accept) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
         end
      end
   end

   assign rx_valid    = valid_q;
   assign rx_dout     = dout_q;
   assign err_parity  = err_parity_q;
   assign err_frame   = err_frame_q;
   assign brk_det     = brk_det_q;
   assign err_overrun = overrun_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: directed frames, expected results queued,
// monitor compares on every accepted output.
module tb_uart_rx_cfg;

   typedef struct packed {
      logic [8:0] dout;
      logic       par;
      logic       frm;
      logic       brk;
      logic       ovr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       s_tick;
   logic       rx;
   logic [3:0] cfg_dbits;
   logic [1:0] cfg_parity;
   logic       cfg_stop2;
   logic       rx_ready;
   logic       rx_valid;
   logic [8:0] rx_dout;
   logic       err_parity, err_frame, brk_det, err_overrun, busy;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;

   uart_rx_cfg #(.D_W(9), .B_TICK(16), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_tick      (s_tick),
      .rx          (rx),
      .cfg_dbits   (cfg_dbits),
      .cfg_parity  (cfg_parity),
      .cfg_stop2   (cfg_stop2),
      .rx_ready    (rx_ready),
      .rx_valid    (rx_valid),
      .rx_dout     (rx_dout),
      .err_parity  (err_parity),
      .err_frame   (err_frame),
      .brk_det     (brk_det),
      .err_overrun (err_overrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   function automatic void push(input logic [8:0] d, input logic p, input logic f,
                                input logic b, input logic o);
      exp_t e;
      e.dout = d; e.par = p; e.frm = f; e.brk = b; e.ovr = o;
      exp_q.push_back(e);
   endfunction

   // Monitor: every accepted holding-register word is checked against the queue.
   always @(negedge clk) begin
      if (!rst && rx_valid && rx_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got dout=0x%03h, required no frame (t=%0t)", rx_dout, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("dout",        32'(rx_dout),     32'(mon_e.dout));
            chk("err_parity",  32'(err_parity),  32'(mon_e.par));
            chk("err_frame",   32'(err_frame),   32'(mon_e.frm));
            chk("brk_det",     32'(brk_det),     32'(mon_e.brk));
            chk("err_overrun", 32'(err_overrun), 32'(mon_e.ovr));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic v, input logic glitch);
      if (glitch) begin
         rx = v;  tick(9);
         rx = ~v; tick(1);
         rx = v;  tick(6);
      end else begin
         rx = v;  tick(16);
      end
   endtask

   task automatic send_frame(input logic [8:0] d, input int nb, input logic has_par,
                             input logic pbit, input logic s1, input logic s2,
                             input logic two, input int glitch_bit);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < nb; i++) send_bit(d[i], i == glitch_bit);
      if (has_par) send_bit(pbit, 1'b0);
      send_bit(s1, 1'b0);
      if (two) send_bit(s2, 1'b0);
      rx = 1'b1;
   endtask

   task automatic set_cfg(input logic [3:0] db, input logic [1:0] par, input logic st2);
      cfg_dbits = db; cfg_parity = par; cfg_stop2 = st2;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; s_tick = 1'b1; rx = 1'b1; rx_ready = 1'b1;
      set_cfg(4'd8, 2'b00, 1'b0);
      tick(4);
      rst = 1'b0;
      chk("rst_valid",   32'(rx_valid),    32'd0);
      chk("rst_dout",    32'(rx_dout),     32'd0);
      chk("rst_par",     32'(err_parity),  32'd0);
      chk("rst_frame",   32'(err_frame),   32'd0);
      chk("rst_brk",     32'(brk_det),     32'd0);
      chk("rst_overrun", 32'(err_overrun), 32'd0);
      chk("rst_busy",    32'(busy),        32'd0);
      tick(20);

      // 8N1 0x55
      push(9'h055, 0, 0, 0, 0);
      send_frame(9'h055, 8, 0, 0, 1, 1, 0, -1);
      tick(32);

      // 8E1 0xA3 with wrong parity bit
      set_cfg(4'd8, 2'b01, 1'b0);
      push(9'h0A3, 1, 0, 0, 0);
      send_frame(9'h0A3, 8, 1, 1, 1, 1, 0, -1);
      tick(32);

      // 5O2 0x1F, correct parity, second stop bit low
      set_cfg(4'd5, 2'b10, 1'b1);
      push(9'h01F, 0, 1, 0, 0);
      send_frame(9'h01F, 5, 1, 0, 1, 0, 1, -1);
      tick(48);

      // Short low glitch on an idle line is a false start
      set_cfg(4'd8, 2'b00, 1'b0);
      rx = 1'b0; tick(4);
      rx = 1'b1; tick(1);
      chk("glitch_busy_hi", 32'(busy), 32'd1);
      tick(15);
      chk("glitch_busy_lo", 32'(busy), 32'd0);
      tick(32);

      // One-tick noise inside data bit 2 is outvoted
      push(9'h00F, 0, 0, 0, 0);
      send_frame(9'h00F, 8, 0, 0, 1, 1, 0, 2);
      tick(32);

      // cfg_dbits above D_W clamps to 9 bits
      set_cfg(4'd15, 2'b00, 1'b0);
      push(9'h1A5, 0, 0, 0, 0);
      send_frame(9'h1A5, 9, 0, 0, 1, 1, 0, -1);
      tick(32);

      // cfg_dbits below 5 clamps to 5 bits; parity code 11 means none
      set_cfg(4'd2, 2'b11, 1'b1);
      push(9'h00B, 0, 0, 0, 0);
      send_frame(9'h00B, 5, 0, 0, 1, 1, 1, -1);
      tick(32);

      // Reset during data bit 3 discards the frame
      set_cfg(4'd8, 2'b00, 1'b0);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      rx = 1'b1; tick(8);
      chk("midrst_busy_hi", 32'(busy), 32'd1);
      rst = 1'b1; tick(2);
      rst = 1'b0;
      chk("midrst_busy_lo", 32'(busy), 32'd0);
      chk("midrst_valid",   32'(rx_valid), 32'd0);
      tick(160);

      // Back-to-back frames with consumer stalled: second one overruns
      rx_ready = 1'b0;
      push(9'h012, 0, 0, 0, 1);
      send_frame(9'h012, 8, 0, 0, 1, 1, 0, -1);
      send_frame(9'h034, 8, 0, 0, 1, 1, 0, -1);
      tick(32);
      chk("ovr_valid_held", 32'(rx_valid),    32'd1);
      chk("ovr_flag_held",  32'(err_overrun), 32'd1);
      rx_ready = 1'b1; tick(1);
      rx_ready = 1'b0;
      chk("ovr_valid_drop", 32'(rx_valid),    32'd0);
      chk("ovr_flag_clear", 32'(err_overrun), 32'd0);
      rx_ready = 1'b1;
      tick(32);

      // Break: three frame times low, then a normal frame must still be received
      push(9'h000, 0, 1, 1, 0);
      rx = 1'b0; tick(480);
      chk("brk_busy_wait", 32'(busy), 32'd1);
      rx = 1'b1; tick(64);
      chk("brk_busy_done", 32'(busy), 32'd0);
      push(9'h0C3, 0, 0, 0, 0);
      send_frame(9'h0C3, 8, 0, 0, 1, 1, 0, -1);
      tick(100);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
